// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end for one shared pipelined multiplier.
// Accepts operand pairs from NREQ requesters and issues one per cycle to
// x2mul/w2mul. The requester id travels down a tag pipeline that lines up
// with the multiplier latency, so each product returns to its owner as a
// registered response.
// Optional feature macro: MUL_ARB_ACC_EN. When defined, it adds req_last and
// per-requester accumulators that sum a group of products and answer once,
// on the last product of the group.
module mul_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    parameter int LAT   = WIDTH + 1,
    parameter int ACCW  = 2 * WIDTH + 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_x,
    input  logic [NREQ*WIDTH-1:0]   req_w,
`ifdef MUL_ARB_ACC_EN
    input  logic [NREQ-1:0]         req_last,
`endif
    output logic [WIDTH-1:0]        x2mul,
    output logic [WIDTH-1:0]        w2mul,
    input  logic [2*WIDTH-1:0]      mul2acc,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [ACCW-1:0]         rsp_data,
    output logic                    busy
);

    // Highest requester index; the round-robin pointer resets here so that
    // the first search after reset starts at requester 0.
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] opX [NREQ];
    logic [WIDTH-1:0] opW [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign opX[gi] = req_x[gi*WIDTH +: WIDTH];
        assign opW[gi] = req_w[gi*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    logic [IDW-1:0]  lastGrantReg;
    logic [IDW-1:0]  grantIdx;
    logic            grantFound;
    logic            accept;
    logic [NREQ-1:0] readyVec;

    // Walk the requesters starting just after the last winner, wrapping at
    // NREQ; the first valid one found wins.
    always_comb begin : rrSearch
        logic [IDW-1:0] cand;
        cand       = lastGrantReg;
        grantIdx   = '0;
        grantFound = 1'b0;
        for (int n = 0; n < NREQ; n++) begin
            cand = (cand == LAST_ID) ? '0 : cand + IDW'(1);
            if (!grantFound && req_valid[cand]) begin
                grantFound = 1'b1;
                grantIdx   = cand;
            end
        end
    end

    // A winner always has valid set, so a grant outside reset is an accept.
    assign accept = grantFound & ~rst;

    // One-hot ready for the winner only; all-zero while in reset or idle.
    always_comb begin
        readyVec = '0;
        if (accept) begin
            readyVec[grantIdx] = 1'b1;
        end
    end

    assign req_ready = readyVec;

    // Remember the winner so the next search starts after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrantReg <= LAST_ID;
        end else if (accept) begin
            lastGrantReg <= grantIdx;
        end
    end

    // ------------------------------------------------------------------
    // Issue to the multiplier
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] x2mulReg;
    logic [WIDTH-1:0] w2mulReg;

    // Register the winner's operands; idle cycles feed zeros so the
    // multiplier never sees stale operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x2mulReg <= '0;
            w2mulReg <= '0;
        end else if (accept) begin
            x2mulReg <= opX[grantIdx];
            w2mulReg <= opW[grantIdx];
        end else begin
            x2mulReg <= '0;
            w2mulReg <= '0;
        end
    end

    assign x2mul = x2mulReg;
    assign w2mul = w2mulReg;

    // ------------------------------------------------------------------
    // Tag pipeline
    // ------------------------------------------------------------------
    // Stage 0 loads together with x2mul/w2mul. The multiplier captures those
    // one edge later and takes LAT edges more to present the product, so
    // stage LAT is the tag that matches mul2acc.
    logic [LAT:0]           tagValidReg;
    logic [LAT:0][IDW-1:0]  tagIdReg;

    // Free-running shift; it cannot stall because the multiplier has no
    // enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagValidReg <= '0;
            tagIdReg    <= '0;
        end else begin
            tagValidReg <= {tagValidReg[LAT-1:0], accept};
            tagIdReg    <= {tagIdReg[LAT-1:0], (accept ? grantIdx : IDW'(0))};
        end
    end

    logic           tailValid;
    logic [IDW-1:0] tailId;
    logic [ACCW-1:0] prodExt;

    assign tailValid = tagValidReg[LAT];
    assign tailId    = tagIdReg[LAT];
    assign prodExt   = ACCW'(mul2acc);

    // ------------------------------------------------------------------
    // Response stage
    // ------------------------------------------------------------------
    logic            rspValidReg;
    logic [IDW-1:0]  rspIdReg;
    logic [ACCW-1:0] rspDataReg;

`ifdef MUL_ARB_ACC_EN
    // The last-of-group flag rides alongside the id.
    logic [LAT:0]    tagLastReg;
    logic            tailLast;
    logic [ACCW-1:0] accReg [NREQ];
    logic [NREQ-1:0] partialReg;
    logic [ACCW-1:0] groupSum;

    // Shift the last flags in step with the valid/id tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagLastReg <= '0;
        end else begin
            tagLastReg <= {tagLastReg[LAT-1:0], accept & req_last[grantIdx]};
        end
    end

    assign tailLast = tagLastReg[LAT];
    // Running total including the returning product; wraps modulo 2^ACCW.
    assign groupSum = accReg[tailId] + prodExt;

    // Fold non-last products into the owner's accumulator; a last product
    // closes the group and clears the accumulator on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                accReg[i] <= '0;
            end
            partialReg <= '0;
        end else if (tailValid) begin
            if (tailLast) begin
                accReg[tailId]     <= '0;
                partialReg[tailId] <= 1'b0;
            end else begin
                accReg[tailId]     <= groupSum;
                partialReg[tailId] <= 1'b1;
            end
        end
    end

    // Only a group's last product produces a response, carrying the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspValidReg <= 1'b0;
            rspIdReg    <= '0;
            rspDataReg  <= '0;
        end else if (tailValid && tailLast) begin
            rspValidReg <= 1'b1;
            rspIdReg    <= tailId;
            rspDataReg  <= groupSum;
        end else begin
            rspValidReg <= 1'b0;
            rspIdReg    <= '0;
            rspDataReg  <= '0;
        end
    end

    // Busy while anything is in flight or a group is still open.
    assign busy = (|tagValidReg) | rspValidReg | (|partialReg);
`else
    // Every returning product becomes a response, zero-extended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspValidReg <= 1'b0;
            rspIdReg    <= '0;
            rspDataReg  <= '0;
        end else if (tailValid) begin
            rspValidReg <= 1'b1;
            rspIdReg    <= tailId;
            rspDataReg  <= prodExt;
        end else begin
            rspValidReg <= 1'b0;
            rspIdReg    <= '0;
            rspDataReg  <= '0;
        end
    end

    // Busy while any tag or the response register holds an operation.
    assign busy = (|tagValidReg) | rspValidReg;
`endif

    assign rsp_valid = rspValidReg;
    assign rsp_id    = rspIdReg;
    assign rsp_data  = rspDataReg;

endmodule

// File: tb/tb_mul_arbiter.sv
// Testbench for mul_arbiter with a behavioural LAT-stage multiplier attached.
// A transaction-level model (round-robin pointer plus a queue of pending
// products with due cycles) is checked against the DUT every cycle. Directed
// tests then pin exact response cycles and values with literal expectations.
module tb_mul_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 2;
    localparam int LAT   = WIDTH + 1;
    localparam int ACCW  = 2 * WIDTH + 4;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_w;
`ifdef MUL_ARB_ACC_EN
    logic [NREQ-1:0]       req_last;
`endif
    logic [WIDTH-1:0]      x2mul;
    logic [WIDTH-1:0]      w2mul;
    logic [2*WIDTH-1:0]    mul2acc;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [ACCW-1:0]       rsp_data;
    logic                  busy;

    mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .ACCW(ACCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_w     (req_w),
`ifdef MUL_ARB_ACC_EN
        .req_last  (req_last),
`endif
        .x2mul     (x2mul),
        .w2mul     (w2mul),
        .mul2acc   (mul2acc),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared multiplier: captures x2mul/w2mul each edge and
    // presents the product LAT edges later.
    logic [2*WIDTH-1:0] mulPipe [LAT];
    always @(posedge clk) begin
        mulPipe[0] <= (2*WIDTH)'(x2mul) * (2*WIDTH)'(w2mul);
        for (int i = 1; i < LAT; i++) mulPipe[i] <= mulPipe[i-1];
    end
    assign mul2acc = mulPipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int assertCount = 0;
    int failCount   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        assertCount++;
        if (act != exp) begin
            failCount++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    typedef struct { int due; int id; longint prod; bit last; } pend_t;
    typedef struct { int c; int id; longint data; } rsp_t;

    pend_t  pend[$];
    rsp_t   rspLog[$];
    int     mLastG = NREQ - 1;
    longint mPrevX = 0;
    longint mPrevW = 0;
    longint accM [NREQ];
    bit     partM [NREQ];
    longint accMask = (longint'(1) << ACCW) - 1;

    // Per-cycle compare at the falling edge, then advance the model.
    always @(negedge clk) begin
        int g;
        int idx;
        bit eV;
        int eId;
        longint eData;
        bit anyPart;
        longint ex;
        longint ew;
        bit el;
        if (rsp_valid) begin
            rspLog.push_back('{c: cyc, id: int'(rsp_id), data: longint'(rsp_data)});
            $display("rsp cycle=%0d id=%0d data=%0d", cyc, rsp_id, rsp_data);
        end
        if (rst) begin
            check("rst_ready", req_ready, 0);
            check("rst_x2mul", x2mul, 0);
            check("rst_w2mul", w2mul, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_busy", busy, 0);
            pend.delete();
            mLastG = NREQ - 1;
            mPrevX = 0;
            mPrevW = 0;
            for (int i = 0; i < NREQ; i++) begin accM[i] = 0; partM[i] = 0; end
        end else begin
            g = -1;
            for (int off = 1; off <= NREQ; off++) begin
                idx = (mLastG + off) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            check("ready", req_ready, (g >= 0) ? (longint'(1) << g) : 0);
            check("x2mul", x2mul, mPrevX);
            check("w2mul", w2mul, mPrevW);
            eV = 0; eId = 0; eData = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                pend_t e;
                e = pend.pop_front();
                if (e.last) begin
                    eV = 1; eId = e.id;
                    eData = (accM[e.id] + e.prod) & accMask;
                    accM[e.id] = 0; partM[e.id] = 0;
                end else begin
                    accM[e.id] = (accM[e.id] + e.prod) & accMask;
                    partM[e.id] = 1;
                end
            end
            check("rsp_valid", rsp_valid, eV);
            check("rsp_id", rsp_id, eId);
            check("rsp_data", rsp_data, eData);
            anyPart = 0;
            for (int i = 0; i < NREQ; i++) anyPart |= partM[i];
            check("busy", busy, (pend.size() > 0 || eV || anyPart) ? 1 : 0);
            if (g >= 0) begin
                ex = longint'(req_x[g*WIDTH +: WIDTH]);
                ew = longint'(req_w[g*WIDTH +: WIDTH]);
`ifdef MUL_ARB_ACC_EN
                el = req_last[g];
`else
                el = 1;
`endif
                pend.push_back('{due: cyc + LAT + 2, id: g, prod: ex * ew, last: el});
                $display("acc cycle=%0d id=%0d x=%0d w=%0d", cyc, g, ex, ew);
                mLastG = g;
                mPrevX = ex;
                mPrevW = ew;
            end else begin
                mPrevX = 0;
                mPrevW = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_x     = '0;
        req_w     = '0;
`ifdef MUL_ARB_ACC_EN
        req_last  = '0;
`endif
    endtask

    task automatic setReq(input int r, input int x, input int w, input bit last);
        req_valid[r]           = 1'b1;
        req_x[r*WIDTH +: WIDTH] = WIDTH'(x);
        req_w[r*WIDTH +: WIDTH] = WIDTH'(w);
`ifdef MUL_ARB_ACC_EN
        req_last[r]            = last;
`else
        if (last) begin end
`endif
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic expectResp(input string name, input int k, input int c, input int id, input longint data);
        if (k < rspLog.size()) begin
            check({name, "_cycle"}, rspLog[k].c, c);
            check({name, "_id"}, rspLog[k].id, id);
            check({name, "_data"}, rspLog[k].data, data);
        end else begin
            check({name, "_missing"}, rspLog.size(), k + 1);
        end
    endtask

    // ---------------- directed tests ----------------
    int s;
    int s2;
    int exp3 [6] = '{1, 2, 4, 4, 9, 6};

    initial begin
        rst = 1'b1;
        idle();
        // Reset held two cycles with every requester asking.
        req_valid = '1;
        step();
        check("t1_ready", req_ready, 0);
        check("t1_busy", busy, 0);
        step();
        rst = 1'b0;
        idle();
        repeat (3) step();

        // Single 15x15 from requester 0.
        rspLog.delete();
        s = cyc;
        setReq(0, 15, 15, 1);
        step();
        idle();
        repeat (10) step();
        expectResp("t2", 0, s + 7, 0, 225);
        check("t2_count", rspLog.size(), 1);

        // Both requesters contending for six cycles.
        doReset();
        rspLog.delete();
        s = cyc;
        for (int j = 0; j < 6; j++) begin
            setReq(0, j / 2 + 1, j / 2 + 1, 1);
            setReq(1, j / 2 + 1, 2, 1);
            step();
        end
        idle();
        repeat (12) step();
        for (int k = 0; k < 6; k++) expectResp("t3", k, s + 7 + k, k % 2, exp3[k]);
        check("t3_count", rspLog.size(), 6);

        // Requester 1 alone, back to back.
        doReset();
        rspLog.delete();
        s = cyc;
        for (int i = 0; i < 8; i++) begin
            setReq(1, i, i, 1);
            step();
        end
        idle();
        repeat (12) step();
        for (int k = 0; k < 8; k++) expectResp("t4", k, s + 7 + k, 1, k * k);
        check("t4_count", rspLog.size(), 8);

        // Reset while three operations are in flight.
        rspLog.delete();
        for (int i = 0; i < 3; i++) begin
            setReq(0, i + 1, i + 1, 1);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (12) step();
        check("t5_dropped", rspLog.size(), 0);
        check("t5_busy", busy, 0);
        s2 = cyc;
        setReq(0, 7, 3, 1);
        step();
        idle();
        repeat (10) step();
        expectResp("t5b", 0, s2 + 7, 0, 21);
        check("t5b_count", rspLog.size(), 1);

`ifdef MUL_ARB_ACC_EN
        // Grouped accumulation: 3*4 + 5*6 + 2*2 = 46, then a lone 1*1.
        rspLog.delete();
        s = cyc;
        setReq(0, 3, 4, 0);
        step();
        setReq(0, 5, 6, 0);
        step();
        setReq(0, 2, 2, 1);
        step();
        idle();
        step();
        s2 = cyc;
        setReq(0, 1, 1, 1);
        step();
        idle();
        repeat (12) step();
        expectResp("t6a", 0, s + 9, 0, 46);
        expectResp("t6b", 1, s2 + 7, 0, 1);
        check("t6_count", rspLog.size(), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and tag tracker that shares one pipelined `boothmul` multiplier between `NREQ` requesters. It accepts unsigned operand pairs over per-requester valid/ready handshakes and drives the multiplier's `x2mul`/`w2mul` inputs. It carries each operation's requester ID through a `LAT`-deep tag pipeline and returns `mul2acc` to the owning requester as a registered response. It sits between the operand sources (lane/sequencer logic) and the shared multiplier in front of the accumulators.

## Interface
Parameters:
- `WIDTH`, 4: operand width; product width is `2*WIDTH`.
- `NREQ`, 2: number of requesters, at least 2; `IDW = $clog2(NREQ)`.
- `LAT`, `WIDTH+1`: multiplier latency. Operands captured at edge k appear on `mul2acc` after edge k+`LAT-1` and are sampled at edge k+`LAT`.
- `ACCW`, `2*WIDTH+4`: response data width.

Ports:
- `clk`, input, 1: clock; all state on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, `NREQ`: request valid, one bit per requester.
- `req_ready`, output, `NREQ`: grant, one-hot or zero.
- `req_x`, input, `NREQ*WIDTH`: packed x operands; requester i uses slice `[i*WIDTH +: WIDTH]`.
- `req_w`, input, `NREQ*WIDTH`: packed w operands, same packing.
- `req_last`, input, `NREQ`: last-of-group flag. Present only with `MUL_ARB_ACC_EN`.
- `x2mul`, output, `WIDTH`: to the multiplier.
- `w2mul`, output, `WIDTH`: to the multiplier.
- `mul2acc`, input, `2*WIDTH`: product from the multiplier.
- `rsp_valid`, output, 1: response valid for one cycle.
- `rsp_id`, output, `IDW`: owning requester.
- `rsp_data`, output, `ACCW`: result.
- `busy`, output, 1: at least one operation in flight.

## Operation
- **Arbitration:** combinational round-robin over `req_valid`.
  - Search starts at `last_grant+1` and wraps modulo `NREQ`.
  - `req_ready[i]` is high only for the winner. It is all-zero when no request is valid or `rst` is high.
  - Accept = `req_valid[i] & req_ready[i]`. At most one accept per cycle, so throughput is 1 operation per cycle.
  - `last_grant` updates only on accept. Its reset value is `NREQ-1`, so requester 0 has priority first.
- **Issue:** on accept, the winner's operands are registered into `x2mul`/`w2mul`. In any cycle without an accept, both are registered to 0.
- **Tag pipeline:** a `LAT+1`-stage shift register of {valid, id}, and {last} with the macro.
  - A stage is loaded on accept and shifted every cycle.
  - The tail stage aligns with a valid `mul2acc`.
  - The pipeline never stalls, because the multiplier has no enable. Responses have no backpressure; consumers must always accept.
- **Response:** a registered stage.
  - When the tail tag is valid: `rsp_valid`=1, `rsp_id`=tag id, `rsp_data`=result (see Configuration).
  - Otherwise `rsp_valid`=0 and `rsp_id`/`rsp_data` hold 0.
- **Ordering:** responses leave in acceptance order, both globally and per requester.
- **Arithmetic:** unsigned product, zero-extended to `ACCW`.
- **`busy`:** OR of all tag valid bits and `rsp_valid`.
- **Reset values:** every output is 0, except `req_ready`, which is 0 while `rst` is high.
- **Reset mid-operation:** all tags, and accumulators when present, clear immediately. In-flight operations are dropped and produce no response after release.

## Timing
- Accept in cycle c (edge k) → `x2mul`/`w2mul` valid in cycle c+1 → product on `mul2acc` in cycle c+1+`LAT` → `rsp_valid` in cycle c+2+`LAT`. Total latency is `LAT+2` cycles; 7 at the defaults.
- Back-to-back accepts in cycles c, c+1 produce responses in cycles c+2+`LAT`, c+3+`LAT`.
- `req_valid` may drop without an accept. Operands must be stable only in the accept cycle.
- First cycle after `rst` deasserts: the arbiter may grant, and requester 0 wins ties.

## Configuration
- `MUL_ARB_ACC_EN` defined:
  - Adds the `req_last` port and `NREQ` accumulators of `ACCW` bits, which wrap modulo `2^ACCW`.
  - A returning tag with last=0 adds its product into that requester's accumulator and emits no response.
  - A returning tag with last=1 emits `rsp_data` = accumulator + product in the response cycle and clears that accumulator in the same edge.
  - `busy` also ORs in "any accumulator holds a partial group".
- `MUL_ARB_ACC_EN` undefined:
  - No `req_last` port and no accumulators.
  - Every operation responds, with `rsp_data` = zero-extended product.

## Test plan
Defaults throughout: `WIDTH`=4, `NREQ`=2, `LAT`=5, with a real `boothmul` attached.
- Hold `rst` for 2 cycles with all requests valid → `req_ready`=00, `x2mul`=`w2mul`=0, `rsp_valid`=0, `busy`=0 throughout.
- Requester 0 sends x=15, w=15, accepted in cycle c → cycle c+7: `rsp_valid`=1, `rsp_id`=0, `rsp_data`=225. No other response.
- Both requesters valid for 6 cycles, requester 0 sending (i,i) and requester 1 sending (i,2) for i=1..3 → grants 0,1,0,1,0,1; six consecutive responses starting at c+7 in order 1,2,4,4,9,6 with ids alternating 0,1.
- Only requester 1 valid for 8 cycles, with operands (i,i) for i=0..7 → granted every cycle; 8 back-to-back responses 0,1,4,…,49, all with id 1.
- Accept 3 operations, then pulse `rst` in cycle c+3 → no `rsp_valid` at any later cycle, `busy`=0 after release, and the next request is accepted normally.
- With `MUL_ARB_ACC_EN`, requester 0 sends (3,4), (5,6), then (2,2,last) → exactly one response, `rsp_data`=46, id 0; a subsequent (1,1,last) responds 1.
